// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter and the units that talk to the integer ALU.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7[5] selects SUB / SRA in the ALU.
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: round-robin on last_grant, or fixed priority to port 0.
module rr_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       grant_valid_o
);

    always_comb begin
        grant_o = 1'b0;
        case (valid_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = FIXED_PRIO ? 1'b0 : ~last_grant_i;
            default: grant_o = 1'b0;
        endcase
        grant_valid_o = |valid_i;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational integer ALU between the execute pipe (port 0) and the
// branch/address-compare unit (port 1); result returns only to the issuing port.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            p0_req_valid_i,
    output logic            p0_req_ready_o,
    input  logic [XLEN-1:0] p0_data_1_i,
    input  logic [XLEN-1:0] p0_data_2_i,
    input  logic [2:0]      p0_funct3_i,
    input  logic [6:0]      p0_funct7_i,
    output logic            p0_resp_valid_o,
    input  logic            p0_resp_ready_i,

    input  logic            p1_req_valid_i,
    output logic            p1_req_ready_o,
    input  logic [XLEN-1:0] p1_data_1_i,
    input  logic [XLEN-1:0] p1_data_2_i,
    input  logic [2:0]      p1_funct3_i,
    input  logic [6:0]      p1_funct7_i,
    output logic            p1_resp_valid_o,
    input  logic            p1_resp_ready_i,

    output logic [XLEN-1:0] resp_data_o,

    output logic [XLEN-1:0] alu_data_1_o,
    output logic [XLEN-1:0] alu_data_2_o,
    output logic [2:0]      alu_funct3_o,
    output logic [6:0]      alu_funct7_o,
    input  logic [XLEN-1:0] alu_result_i
);

    state_e          state;
    logic            last_grant;
    logic            owner;
    logic            grant;
    logic            grant_valid;
    logic            accept;
    logic            owner_resp_ready;
    logic [XLEN-1:0] sel_data_1;
    logic [XLEN-1:0] sel_data_2;
    logic [2:0]      sel_funct3;
    logic [6:0]      sel_funct7;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arbiter2 (
        .valid_i       ({p1_req_valid_i, p0_req_valid_i}),
        .last_grant_i  (last_grant),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // Ready is gated by rst_ni so no handshake is advertised while reset is held.
    assign accept         = (state == IDLE) && rst_ni && grant_valid;
    assign p0_req_ready_o = accept && !grant;
    assign p1_req_ready_o = accept && grant;

    assign owner_resp_ready = owner ? p1_resp_ready_i : p0_resp_ready_i;

    always_comb begin
        sel_data_1 = p0_data_1_i;
        sel_data_2 = p0_data_2_i;
        sel_funct3 = p0_funct3_i;
        sel_funct7 = p0_funct7_i;
        if (grant) begin
            sel_data_1 = p1_data_1_i;
            sel_data_2 = p1_data_2_i;
            sel_funct3 = p1_funct3_i;
            sel_funct7 = p1_funct7_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            owner           <= 1'b0;
            alu_data_1_o    <= '0;
            alu_data_2_o    <= '0;
            alu_funct3_o    <= '0;
            alu_funct7_o    <= '0;
            resp_data_o     <= '0;
            p0_resp_valid_o <= 1'b0;
            p1_resp_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_data_1_o <= sel_data_1;
                        alu_data_2_o <= sel_data_2;
                        alu_funct3_o <= sel_funct3;
                        alu_funct7_o <= sel_funct7;
                        owner        <= grant;
                        last_grant   <= grant;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_o     <= alu_result_i;
                    p0_resp_valid_o <= !owner;
                    p1_resp_valid_o <= owner;
                    state           <= RESP;
                end
                RESP: begin
                    if (owner_resp_ready) begin
                        p0_resp_valid_o <= 1'b0;
                        p1_resp_valid_o <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    p0_resp_valid_o <= 1'b0;
                    p1_resp_valid_o <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority instance share stimulus.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;

    logic            p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic [XLEN-1:0] p0_d1 = '0, p0_d2 = '0, p1_d1 = '0, p1_d2 = '0;
    logic [2:0]      p0_f3 = '0, p1_f3 = '0;
    logic [6:0]      p0_f7 = '0, p1_f7 = '0;
    logic            p0_resp_ready = 1'b1, p1_resp_ready = 1'b1;

    logic            p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
    logic [XLEN-1:0] resp_data, alu_d1, alu_d2, alu_res;
    logic [2:0]      alu_f3;
    logic [6:0]      alu_f7;

    logic            p0_req_ready_f, p1_req_ready_f, p0_resp_valid_f, p1_resp_valid_f;
    logic [XLEN-1:0] resp_data_f, alu_d1_f, alu_d2_f, alu_res_f;
    logic [2:0]      alu_f3_f;
    logic [6:0]      alu_f7_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            F3_ADD_SUB: return f7[5] ? a - b : a + b;
            F3_SLL:     return a << b[4:0];
            F3_SLT:     return {31'd0, $signed(a) < $signed(b)};
            F3_SLTU:    return {31'd0, a < b};
            F3_XOR:     return a ^ b;
            F3_SRL_SRA: return f7[5] ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
            F3_OR:      return a | b;
            default:    return a & b;
        endcase
    endfunction

    always_comb alu_res   = alu_f(alu_d1, alu_d2, alu_f3, alu_f7);
    always_comb alu_res_f = alu_f(alu_d1_f, alu_d2_f, alu_f3_f, alu_f7_f);

    alu_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_valid_i(p0_req_valid), .p0_req_ready_o(p0_req_ready),
        .p0_data_1_i(p0_d1), .p0_data_2_i(p0_d2), .p0_funct3_i(p0_f3), .p0_funct7_i(p0_f7),
        .p0_resp_valid_o(p0_resp_valid), .p0_resp_ready_i(p0_resp_ready),
        .p1_req_valid_i(p1_req_valid), .p1_req_ready_o(p1_req_ready),
        .p1_data_1_i(p1_d1), .p1_data_2_i(p1_d2), .p1_funct3_i(p1_f3), .p1_funct7_i(p1_f7),
        .p1_resp_valid_o(p1_resp_valid), .p1_resp_ready_i(p1_resp_ready),
        .resp_data_o(resp_data),
        .alu_data_1_o(alu_d1), .alu_data_2_o(alu_d2), .alu_funct3_o(alu_f3), .alu_funct7_o(alu_f7),
        .alu_result_i(alu_res)
    );

    alu_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1'b1)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_valid_i(p0_req_valid), .p0_req_ready_o(p0_req_ready_f),
        .p0_data_1_i(p0_d1), .p0_data_2_i(p0_d2), .p0_funct3_i(p0_f3), .p0_funct7_i(p0_f7),
        .p0_resp_valid_o(p0_resp_valid_f), .p0_resp_ready_i(p0_resp_ready),
        .p1_req_valid_i(p1_req_valid), .p1_req_ready_o(p1_req_ready_f),
        .p1_data_1_i(p1_d1), .p1_data_2_i(p1_d2), .p1_funct3_i(p1_f3), .p1_funct7_i(p1_f7),
        .p1_resp_valid_o(p1_resp_valid_f), .p1_resp_ready_i(p1_resp_ready),
        .resp_data_o(resp_data_f),
        .alu_data_1_o(alu_d1_f), .alu_data_2_o(alu_d2_f), .alu_funct3_o(alu_f3_f), .alu_funct7_o(alu_f7_f),
        .alu_result_i(alu_res_f)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents a request, waits (bounded) for its ready, and returns one cycle after the handshake.
    task automatic send(input int p, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [2:0] f3, input logic [6:0] f7);
        int waited = 0;
        if (p == 0) begin
            p0_d1 = a; p0_d2 = b; p0_f3 = f3; p0_f7 = f7; p0_req_valid = 1'b1;
        end else begin
            p1_d1 = a; p1_d2 = b; p1_f3 = f3; p1_f7 = f7; p1_req_valid = 1'b1;
        end
        #1;
        while (!((p == 0) ? p0_req_ready : p1_req_ready) && waited < 20) begin
            tick(); #1;
            waited++;
        end
        chk("send_ready_timeout", 32'(waited < 20), 32'd1);
        tick();
        if (p == 0) p0_req_valid = 1'b0;
        else        p1_req_valid = 1'b0;
    endtask

    logic exp_rr_grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset with both ports already requesting.
        p0_d1 = 32'd10; p0_d2 = 32'd3; p0_f3 = F3_ADD_SUB; p0_f7 = FUNCT7_ALT; p0_req_valid = 1'b1;
        p1_d1 = 32'hFFFF_FFFF; p1_d2 = 32'd1; p1_f3 = F3_SLT; p1_f7 = 7'd0; p1_req_valid = 1'b1;
        tick(); tick(); #1;
        chk("rst_p0_req_ready", 32'(p0_req_ready), 32'd0);
        chk("rst_p1_req_ready", 32'(p1_req_ready), 32'd0);
        chk("rst_resp_valid", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_alu_d1", alu_d1, 32'd0);
        chk("rst_alu_f7", 32'(alu_f7), 32'd0);

        // Both valid after reset: port 0 first (SUB 10-3), then port 1 (SLT -1<1).
        rst_n = 1'b1; #1;
        chk("both_p0_ready", 32'(p0_req_ready), 32'd1);
        chk("both_p1_ready", 32'(p1_req_ready), 32'd0);
        tick(); p0_req_valid = 1'b0; #1;
        chk("exec_p1_ready", 32'(p1_req_ready), 32'd0);
        chk("exec_alu_f7", 32'(alu_f7), 32'h20);
        tick(); #1;
        chk("sub_p0_resp_valid", 32'(p0_resp_valid), 32'd1);
        chk("sub_resp_data", resp_data, 32'd7);
        chk("sub_p1_resp_valid", 32'(p1_resp_valid), 32'd0);
        tick(); #1;
        chk("slt_p1_ready", 32'(p1_req_ready), 32'd1);
        tick(); p1_req_valid = 1'b0;
        tick(); #1;
        chk("slt_p1_resp_valid", 32'(p1_resp_valid), 32'd1);
        chk("slt_resp_data", resp_data, 32'd1);
        tick();

        // Single port 0 ADD: response exactly two cycles after handshake.
        send(0, 32'd5, 32'd7, F3_ADD_SUB, 7'd0); #1;
        chk("add_lat_n1", 32'(p0_resp_valid), 32'd0);
        tick(); #1;
        chk("add_lat_n2", 32'(p0_resp_valid), 32'd1);
        chk("add_resp_data", resp_data, 32'd12);
        chk("add_p1_resp_valid", 32'(p1_resp_valid), 32'd0);
        tick();

        // Backpressure on port 1 AND, with port 0 pending meanwhile.
        p1_resp_ready = 1'b0;
        send(1, 32'hF0F0_F0F0, 32'hFF00_FF00, F3_AND, 7'd0);
        tick();
        p0_d1 = 32'd5; p0_d2 = 32'd7; p0_f3 = F3_ADD_SUB; p0_f7 = 7'd0; p0_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_resp_valid", 32'(p1_resp_valid), 32'd1);
            chk("bp_resp_data", resp_data, 32'hF000_F000);
            chk("bp_alu_d1", alu_d1, 32'hF0F0_F0F0);
            chk("bp_alu_d2", alu_d2, 32'hFF00_FF00);
            chk("bp_req_ready", 32'({p1_req_ready, p0_req_ready}), 32'd0);
            tick();
        end
        p0_req_valid = 1'b0;
        p1_resp_ready = 1'b1;
        tick(); #1;
        chk("bp_done", 32'(p1_resp_valid), 32'd0);

        // Both held valid for four transactions: RR alternates, fixed priority stays on port 0.
        p0_d1 = 32'd5;  p0_d2 = 32'd7;  p0_f3 = F3_ADD_SUB; p0_f7 = 7'd0; p0_req_valid = 1'b1;
        p1_d1 = 32'hFF; p1_d2 = 32'h0F; p1_f3 = F3_XOR;     p1_f7 = 7'd0; p1_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant_p1", 32'(p1_req_ready), 32'(exp_rr_grant[k]));
            chk("rr_grant_p0", 32'(p0_req_ready), 32'(!exp_rr_grant[k]));
            chk("fp_grant_p0", 32'(p0_req_ready_f), 32'd1);
            tick(); tick(); #1;
            chk("rr_resp_data", resp_data, exp_rr_grant[k] ? 32'hF0 : 32'd12);
            chk("fp_resp_data", resp_data_f, 32'd12);
            tick();
        end
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        tick();

        // Response handshake while port 0 already requests again: accepted only next cycle.
        p0_resp_ready = 1'b0;
        send(0, 32'h0F, 32'hF0, F3_OR, 7'd0);
        tick();
        p0_d1 = 32'd1; p0_d2 = 32'd2; p0_f3 = F3_ADD_SUB; p0_f7 = 7'd0; p0_req_valid = 1'b1;
        p0_resp_ready = 1'b1; #1;
        chk("or_resp_data", resp_data, 32'hFF);
        chk("same_cycle_ready", 32'(p0_req_ready), 32'd0);
        tick(); #1;
        chk("next_cycle_ready", 32'(p0_req_ready), 32'd1);
        chk("next_cycle_resp_valid", 32'(p0_resp_valid), 32'd0);
        tick(); p0_req_valid = 1'b0;
        tick(); #1;
        chk("add2_resp_data", resp_data, 32'd3);
        tick();

        // Reset during EXEC of SLL: transaction discarded, then a fresh SLL completes.
        send(0, 32'd1, 32'd4, F3_SLL, 7'd0);
        rst_n = 1'b0; #1;
        chk("mid_rst_alu_d1", alu_d1, 32'd0);
        chk("mid_rst_alu_f3", 32'(alu_f3), 32'd0);
        chk("mid_rst_resp_data", resp_data, 32'd0);
        chk("mid_rst_resp_valid", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("post_rst_no_resp", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
        end
        send(0, 32'd1, 32'd4, F3_SLL, 7'd0);
        tick(); #1;
        chk("sll_resp_valid", 32'(p0_resp_valid), 32'd1);
        chk("sll_resp_data", resp_data, 32'd16);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational integer ALU between two requesters: port 0 is the execute-stage integer pipe, port 1 is the branch/address-compare unit. Each request carries an operand pair plus funct3/funct7. The block arbitrates between the two requesters, registers the granted operands onto the ALU inputs, and captures the ALU result. It then returns the result only to the requester that issued it, over a valid/ready response handshake. It sits between decode/execute control and the ALU instance, and is the only driver of the ALU inputs.

Parameters:
XLEN, 32, operand/result width; must match ALU width.
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
clk_i  in  1  core clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
p0_req_valid_i / p1_req_valid_i  in  1  request valid per port
p0_req_ready_o / p1_req_ready_o  out  1  request accepted this cycle when valid&ready
p0_data_1_i / p1_data_1_i  in  XLEN  operand 1
p0_data_2_i / p1_data_2_i  in  XLEN  operand 2
p0_funct3_i / p1_funct3_i  in  3  ALU funct3
p0_funct7_i / p1_funct7_i  in  7  ALU funct7
p0_resp_valid_o / p1_resp_valid_o  out  1  result valid for that port
p0_resp_ready_i / p1_resp_ready_i  in  1  requester consumes result
resp_data_o  out  XLEN  result, shared bus, meaningful only with a resp_valid
alu_data_1_o / alu_data_2_o  out  XLEN  registered operands to ALU
alu_funct3_o  out  3  registered funct3 to ALU
alu_funct7_o  out  7  registered funct7 to ALU
alu_result_i  in  XLEN  ALU combinational result

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE, last_grant=1 (port 0 wins first), owner=0. All alu_*_o, resp_data_o, resp_valid_o and req_ready_o are 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the two valids. With one valid, that port is granted. With both valid, FIXED_PRIO=1 grants port 0; FIXED_PRIO=0 grants the port that is not last_grant.
  - req_ready_o=1 only for the granted port and only in IDLE; the other port's ready is 0.
  - On handshake: latch the granted operands/funct into the alu_*_o registers, owner=granted port, last_grant=granted port, go to EXEC.
  - No valid: stay in IDLE, alu_*_o hold their previous values.
- EXEC (exactly 1 cycle): ALU evaluates the registered inputs; capture alu_result_i into resp_data_o; go to RESP.
- RESP:
  - resp_valid_o is asserted for owner only.
  - resp_data_o and alu_*_o stay stable until the owner's resp_ready_i=1; on that handshake go to IDLE.
  - The non-owner's resp_ready_i is ignored.
- Latency: request handshake at cycle N, resp_valid high from N+2. Best-case throughput is one op per 3 cycles.
- Backpressure: while in EXEC/RESP both req_ready_o=0; pending requests must hold valid and payload stable.
- A requester dropping valid before handshake is legal; no grant is recorded and last_grant is unchanged.
- The arbiter never modifies operands or funct fields: funct7 passes unmodified, so funct7[5] selects SUB/SRA in the ALU.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, with no response after reset release.
- Simultaneous resp handshake and new request: the new request is not accepted in that cycle. It is accepted at the earliest in the next cycle (IDLE).

Decomposition:
- Package alu_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP}
  - XLEN default
  - funct3 constants (ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111)
  - FUNCT7_ALT=7'b0100000
- Sub-module rr_arbiter2: combinational two-way grant from valids, last_grant and FIXED_PRIO. It is reusable by other shared units.

Test Plan:
- Single port 0 request (ADD, funct3=000, funct7=0, 5, 7) at cycle N -> p0_resp_valid at N+2, resp_data=12; p1_resp_valid stays 0.
- Both valid right after reset: p0 SUB (funct7=0x20, 10, 3), p1 SLT (0xFFFFFFFF, 1) -> p0 served first, resp 7; then p1 served, resp 1.
- Both held valid for 4 transactions (round-robin) -> grants alternate 0,1,0,1. Repeat with FIXED_PRIO=1 -> all 4 grants to port 0.
- Backpressure: p1 AND (0xF0F0F0F0, 0xFF00FF00), p1_resp_ready low for 3 cycles -> resp_data=0xF000F000 stable, alu_*_o stable, both req_ready 0; completes when ready rises.
- Reset pulse during EXEC of p0 SLL (1, 4) -> all outputs 0 immediately; after release no resp_valid; a fresh p0 request returns 16.
- Response handshake with p0_req_valid already high in the same cycle -> p0_req_ready asserted the next cycle, not the same one.
